uart_param_core: RTL
====================

// Module: uart_param_core
// PURPOSE
// - Parametrised full-duplex UART core: TX serialiser + RX deserialiser sharing one clock domain.
// - Configurable width, parity and stop bits; ready/valid handshakes; per-frame error flags; sticky overrun.
// - Sits between board glue (switches/button/LEDs) and the serial pins; a top wires serial_out->serial_in for self-test.
// PARAMETERS
// - CLK_HZ     50_000_000  system clock frequency
// - BAUD       115_200     line rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, must be >= 4)
// - DATA_W     8           data bits per frame, legal 5..9, sent LSB first
// - PARITY     0           0 = none, 1 = even, 2 = odd
// - STOP_BITS  1           1 or 2; RX checks only the first stop bit
// PORTS
// - clk            in   1       system clock, rising edge
// - rst            in   1       asynchronous reset, active low
// - tx_data        in   DATA_W  word to send, sampled when tx_valid & tx_ready
// - tx_valid       in   1       request to send
// - tx_ready       out  1       high in TX IDLE only
// - serial_out     out  1       TX line, idles high
// - serial_in      in   1       RX line, asynchronous to clk
// - rx_data        out  DATA_W  received word, stable while rx_valid
// - rx_valid       out  1       rx_data/flags hold a frame
// - rx_ready       in   1       consumer accepts on rx_valid & rx_ready
// - rx_parity_err  out  1       parity mismatch on held frame (0 when PARITY=0)
// - rx_frame_err   out  1       first stop bit sampled low on held frame
// - rx_overrun     out  1       sticky: frame lost because holding reg full
// - err_clr        in   1       single-cycle clear of rx_overrun
// BEHAVIOUR
// - Reset (rst=0, async): serial_out=1, tx_ready=1, rx_valid=0, rx_data=0, all err flags=0, both FSMs IDLE, counters 0.
// - Reset mid-frame aborts both directions immediately; no partial frame delivered after release.
// - TX FSM: IDLE -> START -> DATA(DATA_W bits) -> PARITY (skipped if PARITY=0) -> STOP(STOP_BITS) -> IDLE.
// - TX accept: tx_data latched; serial_out falls on the next clk edge; each bit held exactly CLKS_PER_BIT cycles.
// - tx_ready low from accept cycle +1 until the last stop bit finishes; tx_valid while busy is ignored.
// - Parity bit = XOR(data) for even, ~XOR(data) for odd.
// - RX: serial_in through 2-FF synchroniser (2-cycle latency) before any use.
// - RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE.
// - IDLE->START on synchronised falling edge; sample at CLKS_PER_BIT/2; if high there: glitch, back to IDLE, nothing reported.
// - Subsequent samples every CLKS_PER_BIT cycles (bit centres); data shifted in LSB first.
// - At STOP sample: frame completes; data + parity/frame errors loaded together; frame with errors still delivered.
// - Holding register: if rx_valid=0, or rx_ready=1 in the same cycle, new frame loads and rx_valid=1.
// - If rx_valid=1 and rx_ready=0 at completion: new frame dropped, held frame kept, rx_overrun set.
// - rx_valid & rx_ready without completion: rx_valid clears next cycle.
// - err_clr and overrun event in same cycle: set wins. RX returns to IDLE right after stop sample (no 2nd stop wait).
// - Bit counters wrap cleanly; bit-period counter width = $clog2(CLKS_PER_BIT).
// CONFIGURATION
// - Macro UART_LOOPBACK_EN: defined -> RX input muxed from internal TX line (serial_in ignored), serial_out still driven.
// - Not defined -> RX uses serial_in only; no mux in netlist. Behaviour otherwise identical.
// STRUCTURE
// - uart_pkg: parity enum (PAR_NONE/PAR_EVEN/PAR_ODD), TX/RX state typedefs, clks_per_bit() function.
// - One sub-module uart_rx_engine (sync, RX FSM, sampling); TX FSM and holding register stay in uart_param_core.
// TESTING (bench uses CLK_HZ=50_000_000, BAUD=5_000_000 -> 10 clks/bit)
// - DATA_W=8, PARITY=1: send 8'hA5 looped -> serial_out 0,1,0,1,0,0,1,0,1,0(par),1; rx_data=8'hA5, no errors.
// - PARITY=2: bench injects frame 8'h0F with parity bit 0 -> rx_parity_err=1, rx_data=8'h0F delivered.
// - Stop bit forced 0 on 8'h3C -> rx_frame_err=1 with rx_valid; next clean frame clears flag.
// - rx_ready held 0, two frames 8'h11,8'h22 -> rx_data stays 8'h11, rx_overrun=1 until err_clr pulse.
// - 3-cycle low glitch on idle serial_in -> no rx_valid, FSM back to IDLE; following frame 8'h7E received correctly.
// - rst asserted mid-DATA of 8'hFF -> serial_out=1, tx_ready=1 immediately; after release 8'h01 round-trips intact.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parameterised UART core.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

    typedef struct packed {
        logic parity_err;
        logic frame_err;
    } rx_flags_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_engine.sv
// UART receive path: 2-FF synchroniser, start-bit qualification, mid-bit sampling.
// Emits a one-cycle frame_done with data and error flags valid in the same cycle.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int CPB    = 10,
    parameter int DATA_W = 8,
    parameter int PARITY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_line,
    output logic              frame_done,
    output logic [DATA_W-1:0] frame_data,
    output rx_flags_t         frame_flags
);

    localparam int CNT_W = $clog2(CPB);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    rx_state_e         state, state_nxt;
    logic [1:0]        sync_q;
    logic              line_s, line_prev, tick;
    logic [CNT_W-1:0]  cnt;
    logic [BIT_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              par_err_q;

    assign line_s = sync_q[1];

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= 2'b11;
            line_prev <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], rx_line};
            line_prev <= line_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RX_IDLE;
        else      state <= state_nxt;
    end

    // First tick lands half a bit into the start bit; later ticks at bit centres.
    assign tick = (state == RX_START) ? (cnt == CNT_HALF) : (cnt == CNT_MAX);

    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE:   if (line_prev && !line_s) state_nxt = RX_START;
            RX_START:  if (tick) state_nxt = line_s ? RX_IDLE : RX_DATA;
            RX_DATA:   if (tick && bit_idx == BIT_LAST)
                           state_nxt = (PARITY != int'(PAR_NONE)) ? RX_PARITY : RX_STOP;
            RX_PARITY: if (tick) state_nxt = RX_STOP;
            RX_STOP:   if (tick) state_nxt = RX_IDLE;
            default:   state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            par_err_q <= 1'b0;
        end else begin
            cnt <= (state == RX_IDLE || tick) ? '0 : cnt + 1'b1;
            if (state == RX_DATA && tick) begin
                shreg   <= {line_s, shreg[DATA_W-1:1]};
                bit_idx <= bit_idx + 1'b1;
            end else if (state != RX_DATA) begin
                bit_idx <= '0;
            end
            if (state == RX_START)
                par_err_q <= 1'b0;
            else if (state == RX_PARITY && tick)
                par_err_q <= (^{shreg, line_s}) != (PARITY == int'(PAR_ODD));
        end
    end

    always_comb begin
        frame_done             = (state == RX_STOP) && tick;
        frame_data             = shreg;
        frame_flags.parity_err = par_err_q;
        frame_flags.frame_err  = ~line_s;
    end

endmodule

// File: rtl/uart_param_core.sv
// Full-duplex UART core: TX serialiser, RX engine and the RX holding register.
// Define UART_LOOPBACK_EN to feed RX from the internal TX line instead of serial_in.
module uart_param_core
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115_200,
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              serial_out,
    input  logic              serial_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_parity_err,
    output logic              rx_frame_err,
    output logic              rx_overrun,
    input  logic              err_clr
);

    localparam int CPB   = clks_per_bit(CLK_HZ, BAUD);
    localparam int CNT_W = $clog2(CPB);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CPB - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    tx_state_e         tx_state, tx_state_nxt;
    logic [CNT_W-1:0]  tx_cnt;
    logic [BIT_W-1:0]  tx_bit;
    logic [DATA_W-1:0] tx_shreg;
    logic              tx_par, tx_tick, tx_line, rx_line;

    assign tx_tick = (tx_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tx_state <= TX_IDLE;
        else      tx_state <= tx_state_nxt;
    end

    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            TX_IDLE:   if (tx_valid) tx_state_nxt = TX_START;
            TX_START:  if (tx_tick) tx_state_nxt = TX_DATA;
            TX_DATA:   if (tx_tick && tx_bit == DATA_LAST)
                           tx_state_nxt = (PARITY != int'(PAR_NONE)) ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tx_tick) tx_state_nxt = TX_STOP;
            TX_STOP:   if (tx_tick && tx_bit == STOP_LAST) tx_state_nxt = TX_IDLE;
            default:   tx_state_nxt = TX_IDLE;
        endcase
    end

    // tx_bit indexes data bits in DATA and stop bits in STOP; cleared on every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
            tx_par   <= 1'b0;
        end else if (tx_state == TX_IDLE) begin
            tx_cnt <= '0;
            tx_bit <= '0;
            if (tx_valid) begin
                tx_shreg <= tx_data;
                tx_par   <= (^tx_data) ^ (PARITY == int'(PAR_ODD));
            end
        end else begin
            tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
            if (tx_state != tx_state_nxt) tx_bit <= '0;
            else if (tx_tick)             tx_bit <= tx_bit + 1'b1;
            if (tx_state == TX_DATA && tx_tick) tx_shreg <= tx_shreg >> 1;
        end
    end

    always_comb begin
        tx_ready = (tx_state == TX_IDLE);
        case (tx_state)
            TX_START:  tx_line = 1'b0;
            TX_DATA:   tx_line = tx_shreg[0];
            TX_PARITY: tx_line = tx_par;
            default:   tx_line = 1'b1;
        endcase
    end

    assign serial_out = tx_line;

`ifdef UART_LOOPBACK_EN
    assign rx_line = tx_line;
`else
    assign rx_line = serial_in;
`endif

    logic              frame_done;
    logic [DATA_W-1:0] frame_data;
    rx_flags_t         frame_flags, rx_flags_q;

    uart_rx_engine #(
        .CPB    (CPB),
        .DATA_W (DATA_W),
        .PARITY (PARITY)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .rx_line     (rx_line),
        .frame_done  (frame_done),
        .frame_data  (frame_data),
        .frame_flags (frame_flags)
    );

    // A frame arriving while the held one is unconsumed is dropped; overrun set beats err_clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_flags_q <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (frame_done && (!rx_valid || rx_ready)) begin
                rx_data    <= frame_data;
                rx_flags_q <= frame_flags;
                rx_valid   <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (frame_done && rx_valid && !rx_ready) rx_overrun <= 1'b1;
            else if (err_clr)                        rx_overrun <= 1'b0;
        end
    end

    assign rx_parity_err = rx_flags_q.parity_err;
    assign rx_frame_err  = rx_flags_q.frame_err;

endmodule
